// File: rtl/kw4281_scan_ctrl.sv
// kw4281_scan_ctrl -- four-digit multiplexed seven-segment scan controller.
//
// The controller scans four common-anode digits one slot at a time. Each slot
// opens with a short all-off blank window that suppresses ghosting, then lights
// the digit for a brightness-proportional number of cycles, then stays dark for
// the rest of the slot. New digit codes arrive through a valid/ready handshake
// and are parked in a one-entry pending register until the frame boundary, so a
// frame never shows a mix of old and new digits.
module kw4281_scan_ctrl #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int SCAN_HZ         = 1000,
  parameter int BLANK_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [15:0] digits_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [3:0]  bright_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        frame_o
);

  // Cycles per digit slot and lit cycles per brightness step.
  localparam int TICK_DIV = CLOCK_FREQUENCY / SCAN_HZ;
  localparam int STEP     = (TICK_DIV - BLANK_CYCLES) / 16;
  localparam int CW       = $clog2(TICK_DIV);

  localparam logic [CW-1:0] C_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);

  // Refuse to build a controller whose slot cannot hold the blank window plus
  // at least one cycle per brightness level.
  if (BLANK_CYCLES < 1 || TICK_DIV < BLANK_CYCLES + 16) begin : g_bad_params
    $fatal(1, "kw4281_scan_ctrl: need BLANK_CYCLES >= 1 and TICK_DIV >= BLANK_CYCLES + 16");
  end

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_ACTIVE,
    ST_OFF
  } state_t;

  // Seven-segment pattern, {g,f,e,d,c,b,a}, active low. Code A is a minus
  // sign; B..F render as a dark digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0111111;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Slot position and per-slot brightness.
  logic [CW-1:0] c;
  logic [1:0]    d;
  logic [3:0]    b;
  state_t        state;

  // Digit storage: what is on display now, and what is queued for next frame.
  logic [15:0]   active_buf;
  logic [15:0]   pending;
  logic          pending_full;

  // Derived per-cycle controls.
  logic          last_cycle;
  logic          frame_end;
  logic [CW-1:0] c_nxt;
  logic [3:0]    b_eff;
  logic [CW-1:0] active_end;
  logic          accept;

  // Decode where the scan is and where it goes on the next edge.
  // NOTE: every signal in a combinational block is assigned on every path
  // through it; a missed assignment would make synthesis infer a latch.
  always_comb begin
    last_cycle = (c == C_LAST);
    frame_end  = last_cycle && (d == 2'd3);
    c_nxt      = last_cycle ? '0 : c + CW'(1);
    // On the first cycle of a slot the brightness latch is being loaded, so
    // decisions made in that cycle look straight at the input.
    b_eff      = (c == '0) ? bright_i : b;
    active_end = C_BLANK + CW'(STEP) * CW'(b_eff);
  end

  assign load_ready_o = !pending_full;
  assign accept       = load_valid_i && load_ready_o;
  assign frame_o      = frame_end;

  // Slot counter, digit index and the brightness sampled at each slot start.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of the order of statements or blocks.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      c <= '0;
      d <= 2'd0;
      b <= 4'd0;
    end else begin
      c <= c_nxt;
      if (last_cycle) begin
        d <= d + 2'd1;
      end
      if (c == '0) begin
        b <= bright_i;
      end
    end
  end

  // Slot FSM with registered drive: outputs change on the same edge that moves
  // c into the blank, lit or dark portion of the slot.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_BLANK;
      an_o  <= 4'b1111;
      seg_o <= 7'b1111111;
    end else begin
      case (state)
        ST_BLANK: begin
          if (c_nxt == C_BLANK) begin
            if (b_eff == 4'd0) begin
              state <= ST_OFF;
            end else begin
              state <= ST_ACTIVE;
              an_o  <= ~(4'b0001 << d);
              seg_o <= seg_decode(active_buf[{d, 2'b00} +: 4]);
            end
          end
        end
        ST_ACTIVE: begin
          if (c_nxt == active_end) begin
            state <= ST_OFF;
            an_o  <= 4'b1111;
            seg_o <= 7'b1111111;
          end
        end
        ST_OFF: begin
          if (last_cycle) begin
            state <= ST_BLANK;
          end
        end
        default: begin
          state <= ST_BLANK;
          an_o  <= 4'b1111;
          seg_o <= 7'b1111111;
        end
      endcase
    end
  end

  // Handshake bookkeeping and the frame-boundary swap into the display buffer.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pending_full <= 1'b0;
      active_buf   <= 16'hFFFF;
    end else if (frame_end) begin
      if (pending_full) begin
        active_buf   <= pending;
        pending_full <= 1'b0;
      end else if (accept) begin
        active_buf <= digits_i;
      end
    end else if (accept) begin
      pending_full <= 1'b1;
    end
  end

  // Pending digit codes; captured on any accept outside the frame boundary.
  // NOTE: this storage has no reset because pending_full guards every read of
  // it; stale contents after reset are never displayed.
  always_ff @(posedge clk) begin
    if (accept && !frame_end) begin
      pending <= digits_i;
    end
  end

endmodule

// File: tb/tb_kw4281_scan_ctrl.sv
// tb_kw4281_scan_ctrl -- self-checking bench for the scan controller.
//
// A cycle-level reference model tracks the scan position as a plain cycle
// count since reset release, the brightness of the current slot, the digits on
// display and a queue of waiting digits. Every simulated cycle is compared
// against it, and each scenario task adds its own targeted comparisons.
module tb_kw4281_scan_ctrl;

  localparam int SLOT  = 64;
  localparam int FRAME = 4 * SLOT;
  localparam int BLANK = 16;
  localparam int STEP  = 3;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };
  localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] digits_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic [3:0]  bright_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        frame_o;

  // Reference model state.
  int          n;
  int          b_slot;
  logic [15:0] disp;
  logic [15:0] pend[$];

  int          n_checks = 0;
  int          n_fails  = 0;

  kw4281_scan_ctrl #(
    .CLOCK_FREQUENCY(64000),
    .SCAN_HZ        (1000),
    .BLANK_CYCLES   (BLANK)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .digits_i    (digits_i),
    .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o),
    .bright_i    (bright_i),
    .an_o        (an_o),
    .seg_o       (seg_o),
    .frame_o     (frame_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    n      = 0;
    b_slot = 0;
    disp   = 16'hFFFF;
    pend.delete();
  endtask

  // One clock cycle: compare the cycle against the model using the inputs
  // currently driven, advance the model across the edge, move to next negedge.
  task automatic tick();
    int          c;
    int          d;
    bit          fe;
    bit          ready;
    bit          acc;
    logic [3:0]  ea;
    logic [6:0]  es;
    c  = n % SLOT;
    d  = (n / SLOT) % 4;
    fe = (d == 3) && (c == SLOT - 1);
    if (c == 0) b_slot = int'(bright_i);
    ready = (pend.size() == 0);
    if (c >= BLANK && c < BLANK + STEP * b_slot) begin
      ea = AN_TAB[d];
      es = SEG_TAB[disp[d*4 +: 4]];
    end else begin
      ea = 4'b1111;
      es = 7'b1111111;
    end
    n_checks++;
    if ({an_o, seg_o, frame_o, load_ready_o} !== {ea, es, fe, ready}) begin
      n_fails++;
      $display("FAIL scan n=%0d c=%0d d=%0d an/seg/frame/ready got %b/%b/%b/%b want %b/%b/%b/%b",
               n, c, d, an_o, seg_o, frame_o, load_ready_o, ea, es, fe, ready);
    end
    acc = load_valid_i && ready;
    if (fe) begin
      if (pend.size() != 0) disp = pend.pop_front();
      else if (acc) disp = digits_i;
    end else if (acc) begin
      pend.push_back(digits_i);
    end
    n++;
    @(negedge clk);
  endtask

  // Advance until the model sits at slot position tc of digit td.
  task automatic run_to(input int tc, input int td);
    do tick(); while (!((n % SLOT) == tc && ((n / SLOT) % 4) == td));
  endtask

  task automatic test_reset();
    rst_i        = 1'b1;
    digits_i     = 16'h0000;
    load_valid_i = 1'b0;
    bright_i     = 4'd15;
    repeat (3) @(negedge clk);
    n_checks++;
    if (an_o !== 4'b1111) begin
      n_fails++; $display("FAIL reset_an got %b want 1111", an_o);
    end
    n_checks++;
    if (seg_o !== 7'b1111111) begin
      n_fails++; $display("FAIL reset_seg got %b want 1111111", seg_o);
    end
    n_checks++;
    if (frame_o !== 1'b0) begin
      n_fails++; $display("FAIL reset_frame got %b want 0", frame_o);
    end
    n_checks++;
    if (load_ready_o !== 1'b1) begin
      n_fails++; $display("FAIL reset_ready got %b want 1", load_ready_o);
    end
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_no_load();
    int pulses = 0;
    bit lit_seg = 1'b0;
    bright_i = 4'd15;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (seg_o !== 7'b1111111) lit_seg = 1'b1;
      if (frame_o === 1'b1) begin
        pulses++;
        n_checks++;
        if ((n % FRAME) != FRAME - 1) begin
          n_fails++; $display("FAIL no_load_frame_pos got %0d want %0d", n % FRAME, FRAME - 1);
        end
      end
      tick();
    end
    n_checks++;
    if (pulses != 2) begin
      n_fails++; $display("FAIL no_load_frame_count got %0d want 2", pulses);
    end
    n_checks++;
    if (lit_seg) begin
      n_fails++; $display("FAIL no_load_seg_blank got lit want 1111111");
    end
  endtask

  task automatic test_load_a123();
    bright_i     = 4'd15;
    digits_i     = 16'hA123;
    load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    run_to(BLANK, 0);
    run_to(BLANK, 0);
    n_checks++;
    if (an_o !== 4'b1110 || seg_o !== 7'b0110000) begin
      n_fails++; $display("FAIL a123_slot0 got %b/%b want 1110/0110000", an_o, seg_o);
    end
    run_to(BLANK + 15 * STEP - 1, 0);
    n_checks++;
    if (an_o !== 4'b1110) begin
      n_fails++; $display("FAIL a123_slot0_c60 got %b want 1110", an_o);
    end
    tick();
    n_checks++;
    if (an_o !== 4'b1111 || seg_o !== 7'b1111111) begin
      n_fails++; $display("FAIL a123_slot0_c61 got %b/%b want 1111/1111111", an_o, seg_o);
    end
    run_to(BLANK - 1, 3);
    n_checks++;
    if (an_o !== 4'b1111) begin
      n_fails++; $display("FAIL a123_slot3_c15 got %b want 1111", an_o);
    end
    tick();
    n_checks++;
    if (an_o !== 4'b0111 || seg_o !== 7'b0111111) begin
      n_fails++; $display("FAIL a123_slot3 got %b/%b want 0111/0111111", an_o, seg_o);
    end
  endtask

  task automatic test_brightness();
    bit lit = 1'b0;
    bright_i = 4'd0;
    run_to(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      if (an_o !== 4'b1111) lit = 1'b1;
      tick();
    end
    n_checks++;
    if (lit) begin
      n_fails++; $display("FAIL bright0_dark_frame got lit want 1111");
    end
    run_to(30, 1);
    bright_i = 4'd1;
    run_to(31, 1);
    n_checks++;
    if (an_o !== 4'b1111) begin
      n_fails++; $display("FAIL bright_midslot got %b want 1111", an_o);
    end
    run_to(BLANK, 2);
    n_checks++;
    if (an_o !== 4'b1011) begin
      n_fails++; $display("FAIL bright1_c16 got %b want 1011", an_o);
    end
    run_to(BLANK + 2, 2);
    n_checks++;
    if (an_o !== 4'b1011) begin
      n_fails++; $display("FAIL bright1_c18 got %b want 1011", an_o);
    end
    tick();
    n_checks++;
    if (an_o !== 4'b1111) begin
      n_fails++; $display("FAIL bright1_c19 got %b want 1111", an_o);
    end
  endtask

  task automatic test_back_to_back();
    bit rose = 1'b0;
    bright_i = 4'd15;
    run_to(10, 1);
    digits_i     = 16'h0001;
    load_valid_i = 1'b1;
    tick();
    n_checks++;
    if (load_ready_o !== 1'b0) begin
      n_fails++; $display("FAIL b2b_ready_drop got %b want 0", load_ready_o);
    end
    digits_i = 16'h0002;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (load_ready_o === 1'b1) begin
        rose = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!rose || (n % FRAME) != 0) begin
      n_fails++; $display("FAIL b2b_ready_return got rose=%0d pos=%0d want rose=1 pos=0", rose, n % FRAME);
    end
    tick();
    load_valid_i = 1'b0;
    run_to(BLANK, 0);
    n_checks++;
    if (an_o !== 4'b1110 || seg_o !== 7'b1111001) begin
      n_fails++; $display("FAIL b2b_show1 got %b/%b want 1110/1111001", an_o, seg_o);
    end
    run_to(BLANK, 0);
    n_checks++;
    if (an_o !== 4'b1110 || seg_o !== 7'b0100100) begin
      n_fails++; $display("FAIL b2b_show2 got %b/%b want 1110/0100100", an_o, seg_o);
    end
  endtask

  task automatic test_frame_end_load();
    run_to(SLOT - 1, 3);
    n_checks++;
    if (load_ready_o !== 1'b1) begin
      n_fails++; $display("FAIL fe_ready_before got %b want 1", load_ready_o);
    end
    digits_i     = 16'h0987;
    load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    n_checks++;
    if (load_ready_o !== 1'b1) begin
      n_fails++; $display("FAIL fe_ready_after got %b want 1", load_ready_o);
    end
    run_to(BLANK, 0);
    n_checks++;
    if (an_o !== 4'b1110 || seg_o !== 7'b1111000) begin
      n_fails++; $display("FAIL fe_show_d0 got %b/%b want 1110/1111000", an_o, seg_o);
    end
    run_to(BLANK, 1);
    n_checks++;
    if (an_o !== 4'b1101 || seg_o !== 7'b0000000) begin
      n_fails++; $display("FAIL fe_show_d1 got %b/%b want 1101/0000000", an_o, seg_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      load_valid_i = ($urandom_range(0, 7) == 0);
      digits_i     = 16'($urandom);
      if ($urandom_range(0, 49) == 0) bright_i = 4'($urandom_range(0, 15));
      tick();
    end
    load_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit lit_seg = 1'b0;
    bright_i = 4'd15;
    run_to(10, 2);
    digits_i     = 16'h5555;
    load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    run_to(30, 2);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (an_o !== 4'b1111 || seg_o !== 7'b1111111) begin
      n_fails++; $display("FAIL midreset_outputs got %b/%b want 1111/1111111", an_o, seg_o);
    end
    n_checks++;
    if (load_ready_o !== 1'b1 || frame_o !== 1'b0) begin
      n_fails++; $display("FAIL midreset_ready_frame got %b/%b want 1/0", load_ready_o, frame_o);
    end
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    n_checks++;
    if (load_ready_o !== 1'b1) begin
      n_fails++; $display("FAIL midreset_release_ready got %b want 1", load_ready_o);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (seg_o !== 7'b1111111) lit_seg = 1'b1;
      tick();
    end
    n_checks++;
    if (lit_seg) begin
      n_fails++; $display("FAIL midreset_blank_display got lit want 1111111");
    end
  endtask

  initial begin
    test_reset();
    test_no_load();
    test_load_a123();
    test_brightness();
    test_back_to_back();
    test_frame_end_load();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/kw4281_scan_ctrl.md
KW4281_SCAN_CTRL -- requirements
Module: kw4281_scan_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 100000000, clk frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, digit slot rate in Hz; TICK_DIV = CLOCK_FREQUENCY/SCAN_HZ cycles per slot.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghosting blank cycles at the start of each slot.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port digits_i, input, 16, four 4-bit codes; [3:0] = digit0 (rightmost) through [15:12] = digit3.
REQ-007 SHALL have port load_valid_i, input, 1, digits_i valid.
REQ-008 SHALL have port load_ready_o, output, 1, controller can accept digits_i.
REQ-009 SHALL have port bright_i, input, 4, brightness 0 (dark) to 15 (max).
REQ-010 SHALL have port an_o, output, 4, digit enables, active low, registered.
REQ-011 SHALL have port seg_o, output, 7, {g,f,e,d,c,b,a}, active low, registered.
REQ-012 SHALL have port frame_o, output, 1, one-cycle pulse on the last cycle of each frame.

Function
REQ-013 SHALL fail elaboration unless BLANK_CYCLES >= 1 and TICK_DIV >= BLANK_CYCLES+16; STEP = (TICK_DIV-BLANK_CYCLES)/16, floored.
REQ-014 SHALL keep slot counter c (0..TICK_DIV-1) and digit index d (0..3); c wraps to 0 and d increments mod 4 on c = TICK_DIV-1; 4 slots = 1 frame.
REQ-015 SHALL latch bright_i into b at c = 0 of every slot; bright_i changes mid-slot have no effect until the next slot.
REQ-016 SHALL run FSM BLANK -> ACTIVE -> OFF per slot: BLANK for c < BLANK_CYCLES; ACTIVE for BLANK_CYCLES <= c < BLANK_CYCLES+STEP*b; OFF for the remaining cycles up to c = TICK_DIV-1; then BLANK of the next slot.
REQ-017 SHALL skip ACTIVE when b = 0, going BLANK -> OFF.
REQ-018 SHALL drive an_o = 4'b1111 and seg_o = 7'b1111111 in BLANK and OFF.
REQ-019 SHALL drive seg_o = decode of the active-buffer code of digit d in ACTIVE, with an_o: d0=1110, d1=1101, d2=1011, d3=0111.
REQ-020 SHALL decode codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0111111 (minus), B-F=1111111 (blank).
REQ-021 SHALL make the output register timing so that a slot's outputs change on the clock edge where c enters the new state; c = 0 of slot 0 is the first edge after rst_i deasserts.
REQ-022 SHALL accept digits_i into a pending register when load_valid_i && load_ready_o; load_ready_o = !pending_full.
REQ-023 SHALL copy pending into the active buffer and clear pending_full at frame end (d = 3, c = TICK_DIV-1); the new digits take effect from slot 0 of the next frame, with no tearing within a frame.
REQ-024 SHALL, when an accept occurs on the frame-end cycle with pending empty, write digits_i directly into the active buffer and leave pending_full clear.
REQ-025 SHALL pulse frame_o high for exactly the frame-end cycle.

Reset
REQ-026 SHALL, while rst_i = 1 (asynchronously), force an_o = 1111, seg_o = 1111111, frame_o = 0, load_ready_o = 1, c = 0, d = 0, b = 0, FSM = BLANK, pending_full = 0, and active buffer = 4 x 4'hF (blank).
REQ-027 SHALL discard any pending data and in-progress slot on reset assertion mid-operation.

Verification (CLOCK_FREQUENCY=64000, SCAN_HZ=1000 -> TICK_DIV=64, BLANK_CYCLES=16, STEP=3)
REQ-028 SHALL check: reset released, no load, bright=15 -> an_o pulses one-hot low on c=16..60 of each slot, seg_o = 1111111 always, frame_o every 256 cycles.
REQ-029 SHALL check: load 16'hA123 once, bright=15 -> from next frame, slot0 c=16..60 an_o=1110 seg_o=0110000; slot3 an_o=0111 seg_o=0111111; c=0..15 and 61..63 all-off.
REQ-030 SHALL check: bright=0 -> an_o = 1111 for entire frames; bright changed to 1 mid-slot -> active only c=16..18 starting at the next slot.
REQ-031 SHALL check: two back-to-back loads 16'h0001 then 16'h0002 mid-frame -> first accepted and ready drops; second held until the frame-end cycle; display shows 1, then 2 one frame later.
REQ-032 SHALL check: load offered exactly on the frame-end cycle with pending empty -> shown from the very next slot 0, with load_ready_o staying 1.
REQ-033 SHALL check: rst_i asserted at c=30 of slot 2 -> an_o=1111 and seg_o=1111111 immediately; after release, blank display and load_ready_o=1.
